// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared codes for the HI/LO multiply/divide sequencer: SPECIAL funct values,
// sequencer states and the HI/LO-writer predicate.
package hilo_muldiv_ctrl_pkg;

  typedef logic [5:0] func_t;

  localparam func_t FUNC_MFHI  = 6'h10;
  localparam func_t FUNC_MTHI  = 6'h11;
  localparam func_t FUNC_MFLO  = 6'h12;
  localparam func_t FUNC_MTLO  = 6'h13;
  localparam func_t FUNC_MULT  = 6'h18;
  localparam func_t FUNC_MULTU = 6'h19;
  localparam func_t FUNC_DIV   = 6'h1A;
  localparam func_t FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_FIX
  } muldiv_state_t;

  function automatic logic is_hilo_write(input func_t f);
    case (f)
      FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_divider_core.sv
// Unsigned restoring divider resolving BITS_PER_CYCLE quotient bits per cycle.
// Works on magnitudes only; sign handling belongs to the caller.
module divider_core #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned ITER  = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER);

  logic [CNT_W-1:0] count;
  logic             running;
  logic [31:0]      dvsr;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      rem_n;
  logic [31:0]      quo_n;
  logic [32:0]      shifted;

  // quo_q doubles as the dividend shift register: its MSBs feed the remainder.
  always_comb begin
    rem_n   = rem_q;
    quo_n   = quo_q;
    shifted = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_n, quo_n[31]};
      quo_n   = {quo_n[30:0], 1'b0};
      if (shifted >= {1'b0, dvsr}) begin
        shifted  = shifted - {1'b0, dvsr};
        quo_n[0] = 1'b1;
      end
      rem_n = shifted[31:0];
    end
  end

  // High during the final iteration; results are valid from the next cycle.
  assign done      = running && (count == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      dvsr    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= CNT_W'(ITER - 1);
      dvsr    <= divisor;
      rem_q   <= '0;
      quo_q   <= dividend;
    end else if (running) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the execute stage: single-cycle MULT/MULTU, MTHI/MTLO,
// iterative DIV/DIVU, and the stall for HI/LO readers/writers during a divide.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  func_t       funct_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        read_hi_i,
  input  logic        read_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o
);

  muldiv_state_t state;
  logic          accept;
  logic          div_go;
  logic          signed_div;
  logic [31:0]   dvd_mag;
  logic [31:0]   dvs_mag;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          q_neg;
  logic          r_neg;
  logic          core_done;
  logic [31:0]   quotient;
  logic [31:0]   remainder;

  always_comb begin
    accept     = start_i && (state == IDLE) && is_hilo_write(funct_i);
    signed_div = (funct_i == FUNC_DIV);
    div_go     = accept && (signed_div || (funct_i == FUNC_DIVU));
    dvd_mag    = (signed_div && rs_i[31]) ? (~rs_i + 32'd1) : rs_i;
    dvs_mag    = (signed_div && rt_i[31]) ? (~rt_i + 32'd1) : rt_i;
    prod_s     = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    prod_u     = {32'd0, rs_i} * {32'd0, rt_i};
  end

  divider_core #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_divider_core (
    .clk      (clk),
    .reset    (reset),
    .start    (div_go),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .done     (core_done),
    .quotient (quotient),
    .remainder(remainder)
  );

  assign stall_o = busy_o && (read_hi_i || read_lo_i || start_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi_o   <= '0;
      lo_o   <= '0;
      busy_o <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (funct_i)
              FUNC_MULT:  {hi_o, lo_o} <= prod_s;
              FUNC_MULTU: {hi_o, lo_o} <= prod_u;
              FUNC_MTHI:  hi_o <= rs_i;
              FUNC_MTLO:  lo_o <= rs_i;
              // accept already restricts funct to HI/LO writers: DIV or DIVU here
              default: begin
                q_neg  <= signed_div && (rs_i[31] ^ rt_i[31]);
                r_neg  <= signed_div && rs_i[31];
                busy_o <= 1'b1;
                state  <= DIV_RUN;
              end
            endcase
          end
        end
        DIV_RUN: begin
          if (core_done) state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo_o   <= q_neg ? (~quotient + 32'd1) : quotient;
          hi_o   <= r_neg ? (~remainder + 32'd1) : remainder;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl; three instances cover BITS_PER_CYCLE 1, 2, 4.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk;
  logic        rst     [3];
  logic        start   [3];
  logic [5:0]  funct   [3];
  logic [31:0] rs      [3];
  logic [31:0] rt      [3];
  logic        read_hi [3];
  logic        read_lo [3];
  logic [31:0] hi      [3];
  logic [31:0] lo      [3];
  logic        busy    [3];
  logic        stall   [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hilo_muldiv_ctrl #(
      .BITS_PER_CYCLE(1 << g)
    ) dut (
      .clk      (clk),
      .reset    (rst[g]),
      .start_i  (start[g]),
      .funct_i  (funct[g]),
      .rs_i     (rs[g]),
      .rt_i     (rt[g]),
      .read_hi_i(read_hi[g]),
      .read_lo_i(read_lo[g]),
      .hi_o     (hi[g]),
      .lo_o     (lo[g]),
      .busy_o   (busy[g]),
      .stall_o  (stall[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t          e;
    longint        sa, sbv, q, r, p;
    longint unsigned ua, ub, pu;
    e.hi = '0;
    e.lo = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (f)
      FUNC_MULT:  begin p = sa * sbv; {e.hi, e.lo} = p; end
      FUNC_MULTU: begin pu = ua * ub; {e.hi, e.lo} = pu; end
      FUNC_DIV: begin
        if (b == 32'd0) begin
          e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      FUNC_DIVU: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          pu = ua / ub;
          e.lo = pu[31:0];
          pu = ua % ub;
          e.hi = pu[31:0];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Drives one op at posedge+1 so it is accepted on the following edge.
  task automatic issue(input int k, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start[k] = 1'b1;
    funct[k] = f;
    rs[k]    = a;
    rt[k]    = b;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  // Counts cycles with busy high; returns with busy low or the bound exhausted.
  task automatic wait_idle(input int k, output int n, output bit timeout);
    n = 0;
    while (busy[k] && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    timeout = busy[k];
  endtask

  task automatic test_reset(input int k);
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[k]     = 1'b0;
    read_hi[k] = 1'b1;
    #1;
    checks++;
    if (hi[k] !== 32'd0 || lo[k] !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo[%0d]: hi=%h lo=%h, required 0/0", k, hi[k], lo[k]);
    end
    checks++;
    if (busy[k] !== 1'b0 || stall[k] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_stall[%0d]: busy=%b stall=%b, required 0/0", k, busy[k], stall[k]);
    end
    read_hi[k] = 1'b0;
  endtask

  task automatic test_mult(input int k);
    vec_t        tbl[2];
    exp_t        e;
    logic [5:0]  f;
    logic [31:0] a, b;
    tbl[0] = '{f: FUNC_MULT,  a: 32'hFFFF_FFFE, b: 32'd3, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA};
    tbl[1] = '{f: FUNC_MULTU, a: 32'hFFFF_FFFE, b: 32'd3, hi: 32'h0000_0002, lo: 32'hFFFF_FFFA};
    foreach (tbl[i]) begin
      sb.push_back('{hi: tbl[i].hi, lo: tbl[i].lo});
      issue(k, tbl[i].f, tbl[i].a, tbl[i].b);
      e = sb.pop_front();
      checks++;
      if (hi[k] !== e.hi || lo[k] !== e.lo || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL mult[%0d.%0d]: hi=%h lo=%h busy=%b, required %h %h 0",
                 k, i, hi[k], lo[k], busy[k], e.hi, e.lo);
      end
    end
    for (int i = 0; i < 4; i++) begin
      f = (i % 2 == 0) ? FUNC_MULT : FUNC_MULTU;
      a = $urandom;
      b = $urandom;
      sb.push_back(model(f, a, b));
      issue(k, f, a, b);
      e = sb.pop_front();
      checks++;
      if (hi[k] !== e.hi || lo[k] !== e.lo) begin
        errors++;
        $display("FAIL mult_rand[%0d.%0d]: %h*%h hi=%h lo=%h, required %h %h",
                 k, i, a, b, hi[k], lo[k], e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div(input int k);
    vec_t tbl[5];
    exp_t e;
    int   n;
    bit   to;
    tbl[0] = '{f: FUNC_DIV,  a: 32'hFFFF_FFF9, b: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    tbl[1] = '{f: FUNC_DIVU, a: 32'd100,       b: 32'd7,         hi: 32'd2,         lo: 32'd14};
    tbl[2] = '{f: FUNC_DIVU, a: 32'd5,         b: 32'd0,         hi: 32'd5,         lo: 32'hFFFF_FFFF};
    tbl[3] = '{f: FUNC_DIV,  a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'd0,         lo: 32'h8000_0000};
    tbl[4] = '{f: FUNC_DIV,  a: 32'hFFFF_FFFB, b: 32'd0,         hi: 32'hFFFF_FFFB, lo: 32'h0000_0001};
    foreach (tbl[i]) begin
      sb.push_back('{hi: tbl[i].hi, lo: tbl[i].lo});
      issue(k, tbl[i].f, tbl[i].a, tbl[i].b);
      wait_idle(k, n, to);
      e = sb.pop_front();
      checks++;
      if (to || n != (32 >> k) + 1) begin
        errors++;
        $display("FAIL div_busy_len[%0d.%0d]: busy cycles=%0d timeout=%b, required %0d",
                 k, i, n, to, (32 >> k) + 1);
      end
      checks++;
      if (hi[k] !== e.hi || lo[k] !== e.lo) begin
        errors++;
        $display("FAIL div_result[%0d.%0d]: hi=%h lo=%h, required %h %h", k, i, hi[k], lo[k], e.hi, e.lo);
      end
    end
  endtask

  task automatic test_stall(input int k);
    exp_t e;
    int   n;
    bit   bad;
    sb.push_back(model(FUNC_DIV, 32'h1234_5678, 32'hFFFF_FEEF));
    issue(k, FUNC_DIV, 32'h1234_5678, 32'hFFFF_FEEF);
    n   = 0;
    bad = 1'b0;
    while (busy[k] && n < 200) begin
      n++;
      if (n == 5) read_lo[k] = 1'b1;
      #1;
      if (stall[k] !== (n >= 5)) bad = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    e = sb.pop_front();
    checks++;
    if (bad || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL stall_during_busy[%0d]: stall pattern wrong or busy stuck (busy=%b)", k, busy[k]);
    end
    checks++;
    if (stall[k] !== 1'b0 || lo[k] !== e.lo || hi[k] !== e.hi) begin
      errors++;
      $display("FAIL stall_release[%0d]: stall=%b hi=%h lo=%h, required 0 %h %h",
               k, stall[k], hi[k], lo[k], e.hi, e.lo);
    end
    read_lo[k] = 1'b0;
  endtask

  task automatic test_back_to_back(input int k);
    exp_t e;
    int   n;
    bit   bad;
    sb.push_back(model(FUNC_DIVU, 32'd1000, 32'd3));
    issue(k, FUNC_DIVU, 32'd1000, 32'd3);
    start[k] = 1'b1;
    funct[k] = FUNC_MTHI;
    rs[k]    = 32'hDEAD_BEEF;
    rt[k]    = 32'd0;
    n   = 0;
    bad = 1'b0;
    while (busy[k] && n < 200) begin
      n++;
      #1;
      if (stall[k] !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    e = sb.pop_front();
    checks++;
    if (bad || n != (32 >> k) + 1) begin
      errors++;
      $display("FAIL b2b_stall[%0d]: stall dropped during busy or busy cycles=%0d, required %0d",
               k, n, (32 >> k) + 1);
    end
    checks++;
    if (stall[k] !== 1'b0 || hi[k] !== e.hi || lo[k] !== e.lo) begin
      errors++;
      $display("FAIL b2b_div_result[%0d]: stall=%b hi=%h lo=%h, required 0 %h %h",
               k, stall[k], hi[k], lo[k], e.hi, e.lo);
    end
    @(posedge clk); #1;
    start[k] = 1'b0;
    checks++;
    if (hi[k] !== 32'hDEAD_BEEF || lo[k] !== e.lo || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mthi[%0d]: hi=%h lo=%h busy=%b, required deadbeef %h 0",
               k, hi[k], lo[k], busy[k], e.lo);
    end
  endtask

  task automatic test_reset_mid(input int k);
    int cyc;
    issue(k, FUNC_MTHI, 32'h11, 32'd0);
    issue(k, FUNC_MTLO, 32'h22, 32'd0);
    checks++;
    if (hi[k] !== 32'h11 || lo[k] !== 32'h22) begin
      errors++;
      $display("FAIL mthi_mtlo[%0d]: hi=%h lo=%h, required 11 22", k, hi[k], lo[k]);
    end
    cyc = ((32 >> k) + 1 > 10) ? 10 : (16 >> k);
    issue(k, FUNC_DIVU, 32'd1000, 32'd3);
    repeat (cyc - 1) @(posedge clk);
    #1;
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    checks++;
    if (busy[k] !== 1'b0 || hi[k] !== 32'd0 || lo[k] !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_div[%0d]: busy=%b hi=%h lo=%h, required 0 0 0", k, busy[k], hi[k], lo[k]);
    end
    repeat ((32 >> k) + 3) @(posedge clk);
    #1;
    checks++;
    if (busy[k] !== 1'b0 || hi[k] !== 32'd0 || lo[k] !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_late_write[%0d]: busy=%b hi=%h lo=%h, required 0 0 0",
               k, busy[k], hi[k], lo[k]);
    end
  endtask

  task automatic test_div_random(input int k);
    exp_t        e;
    logic [5:0]  f;
    logic [31:0] a, b;
    int          n;
    bit          to;
    for (int i = 0; i < 6; i++) begin
      f = ($urandom_range(0, 1) == 1) ? FUNC_DIV : FUNC_DIVU;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
      if (i == 3) b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      sb.push_back(model(f, a, b));
      issue(k, f, a, b);
      wait_idle(k, n, to);
      e = sb.pop_front();
      checks++;
      if (to || hi[k] !== e.hi || lo[k] !== e.lo) begin
        errors++;
        $display("FAIL div_rand[%0d.%0d]: f=%h %h/%h hi=%h lo=%h timeout=%b, required %h %h",
                 k, i, f, a, b, hi[k], lo[k], to, e.hi, e.lo);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]     = 1'b1;
      start[k]   = 1'b0;
      funct[k]   = '0;
      rs[k]      = '0;
      rt[k]      = '0;
      read_hi[k] = 1'b0;
      read_lo[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      test_reset(k);
      test_mult(k);
      test_div(k);
      test_stall(k);
      test_back_to_back(k);
      test_reset_mid(k);
      test_div_random(k);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
